// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core load/store port.
// Accepts one request per handshake and, after WAIT_CYCLES extra cycles,
// performs the access on an internal little-endian byte RAM. The load data
// (sign/zero-extended) or a store completion is returned on a valid/ready
// response channel.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake
//   req_write                   1 = store, 0 = load
//   req_funct3                  RV32 width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr, req_wdata         byte address, store data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_error        extended load data (0 for stores/faults), fault flag
module mem_responder #(
  parameter int WORDS       = 16384,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int          NBYTES    = WORDS * 4;
  localparam int          MBITS     = NBYTES * 8;
  localparam int          BW        = $clog2(MBITS);
  localparam logic [31:0] MAX_ADDR  = 32'(NBYTES - 1);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  // Byte i at mem[i*8 +: 8]; deliberately not reset.
  logic [MBITS-1:0] mem;

  // Access operands. With WAIT_CYCLES == 0 the access happens on the
  // acceptance edge, so in IDLE it must use the live request, not the latch.
  logic        a_write;
  logic [2:0]  a_f3;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_err;
  logic [3:0]  a_be;
  logic [BW-1:0] wbase;
  logic [31:0] word, word_sh, ldata, wdata_sh;
  logic        go_resp;

  always_comb begin
    if (state_q == IDLE) begin
      a_write = req_write;
      a_f3    = req_funct3;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end else begin
      a_write = write_q;
      a_f3    = f3_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  // Fault and byte-enable decode.
  always_comb begin
    a_err = (a_addr > MAX_ADDR);
    a_be  = 4'b0000;
    if (a_write) begin
      case (a_f3)
        3'd0:    a_be = 4'b0001;
        3'd1:    begin a_be = 4'b0011; if (a_addr[0])          a_err = 1'b1; end
        3'd2:    begin a_be = 4'b1111; if (a_addr[1:0] != 2'd0) a_err = 1'b1; end
        default: a_err = 1'b1;
      endcase
    end else begin
      case (a_f3)
        3'd0, 3'd4: ;
        3'd1, 3'd5: if (a_addr[0])          a_err = 1'b1;
        3'd2:       if (a_addr[1:0] != 2'd0) a_err = 1'b1;
        default:    a_err = 1'b1;
      endcase
    end
    // Misaligned shifts only truncate; the fault flag blocks them anyway.
    a_be = a_be << a_addr[1:0];
  end

  // Load path: fetch the containing word, align the addressed lane to bit 0.
  always_comb begin
    wbase    = {a_addr[BW-4:2], 5'b00000};
    word     = mem[wbase +: 32];
    word_sh  = word >> {a_addr[1:0], 3'b000};
    wdata_sh = a_wdata << {a_addr[1:0], 3'b000};
    case (a_f3)
      3'd0:    ldata = {{24{word_sh[7]}}, word_sh[7:0]};
      3'd1:    ldata = {{16{word_sh[15]}}, word_sh[15:0]};
      3'd4:    ldata = {24'd0, word_sh[7:0]};
      3'd5:    ldata = {16'd0, word_sh[15:0]};
      default: ldata = word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    go_resp     = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (WAIT_CYCLES == 0) go_resp = 1'b1;
        else begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) go_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_error_d = a_err;
      rsp_rdata_d = (a_err || a_write) ? 32'd0 : ldata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Store commit on the edge entering RESP. state_q sits in IDLE during
  // reset, so an abandoned WAIT never reaches this.
  always_ff @(posedge clk) begin
    if (go_resp && a_write && !a_err)
      for (int b = 0; b < 4; b++)
        if (a_be[b]) mem[wbase + BW'(8 * b) +: 8] <= wdata_sh[8 * b +: 8];
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 1, 4, 0) share the
// request payload; each has its own valid/ready/reset.
module tb_mem_responder;
  localparam int WORDS = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_error [3];
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));
  mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));
  mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2]));

  typedef struct {
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    bit        err;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];

  function automatic vec_t mk(bit wr, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                              bit [31:0] rdata, bit err);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  function automatic int wc_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // One full transaction on instance k; expectation goes through the scoreboard.
  task automatic txn(input int k, input vec_t v, input string nm);
    int   lat;
    vec_t e;
    sb.push_back(v);
    @(negedge clk);
    chkb({nm, ".req_ready"}, req_ready[k], 1'b1);
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chkb({nm, ".rsp_valid"}, rsp_valid[k], 1'b1);
    chk({nm, ".latency"}, 32'(lat), 32'(wc_of(k) + 1));
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.scoreboard: got empty want entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".rdata"}, rsp_rdata[k], e.rdata);
      chkb({nm, ".error"}, rsp_error[k], e.err);
    end
    @(negedge clk);
    chkb({nm, ".done_valid"}, rsp_valid[k], 1'b0);
    chkb({nm, ".done_ready"}, req_ready[k], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   n;
    bit   seen;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    end
    req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset and idle
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chkb($sformatf("rst%0d.req_ready", k), req_ready[k], 1'b1);
      chkb($sformatf("rst%0d.rsp_valid", k), rsp_valid[k], 1'b0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chkb("idle.req_ready", req_ready[0], 1'b1);
      chkb("idle.rsp_valid", rsp_valid[0], 1'b0);
      chk("idle.rsp_rdata", rsp_rdata[0], 32'd0);
      chkb("idle.rsp_error", rsp_error[0], 1'b0);
    end

    // Vector table (instance with WAIT_CYCLES=1)
    tbl.push_back(mk(1, 3'd2, 32'h80,  32'h9234F058, 32'h0,        0)); // preload
    tbl.push_back(mk(0, 3'd2, 32'h80,  32'h0,        32'h9234F058, 0)); // LW
    tbl.push_back(mk(0, 3'd0, 32'h81,  32'h0,        32'hFFFFFFF0, 0)); // LB
    tbl.push_back(mk(0, 3'd4, 32'h81,  32'h0,        32'h000000F0, 0)); // LBU
    tbl.push_back(mk(0, 3'd1, 32'h82,  32'h0,        32'hFFFF9234, 0)); // LH
    tbl.push_back(mk(0, 3'd5, 32'h82,  32'h0,        32'h00009234, 0)); // LHU
    tbl.push_back(mk(0, 3'd0, 32'h80,  32'h0,        32'h00000058, 0)); // LB positive
    tbl.push_back(mk(0, 3'd0, 32'h83,  32'h0,        32'hFFFFFF92, 0)); // LB top lane
    tbl.push_back(mk(1, 3'd2, 32'h78,  32'h11223344, 32'h0,        0));
    tbl.push_back(mk(1, 3'd0, 32'h79,  32'hAAAAAA58, 32'h0,        0)); // SB
    tbl.push_back(mk(0, 3'd2, 32'h78,  32'h0,        32'h11225844, 0));
    tbl.push_back(mk(1, 3'd1, 32'h7A,  32'h0000BEEF, 32'h0,        0)); // SH
    tbl.push_back(mk(0, 3'd2, 32'h78,  32'h0,        32'hBEEF5844, 0));
    tbl.push_back(mk(1, 3'd2, 32'h78,  32'hDEADBEEF, 32'h0,        0)); // SW
    tbl.push_back(mk(0, 3'd2, 32'h78,  32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 3'd2, 32'h100, 32'hCAFEBABE, 32'h0,        0));
    tbl.push_back(mk(0, 3'd1, 32'h101, 32'h0,        32'h0,        1)); // LH misaligned
    tbl.push_back(mk(1, 3'd2, 32'h102, 32'h11111111, 32'h0,        1)); // SW misaligned
    tbl.push_back(mk(0, 3'd2, 32'(WORDS * 4), 32'h0, 32'h0,        1)); // past end
    tbl.push_back(mk(0, 3'd2, 32'hFFFFFF00, 32'h0,   32'h0,        1)); // no wrap
    tbl.push_back(mk(0, 3'd3, 32'h100, 32'h0,        32'h0,        1)); // bad load f3
    tbl.push_back(mk(1, 3'd4, 32'h100, 32'h22222222, 32'h0,        1)); // bad store f3
    tbl.push_back(mk(1, 3'd0, 32'h100, 32'h33333333, 32'h0,        0)); // SB ok -> BE
    tbl.push_back(mk(0, 3'd2, 32'h100, 32'h0,        32'hCAFEBA33, 0));
    tbl.push_back(mk(1, 3'd2, 32'h1FC, 32'h0BADF00D, 32'h0,        0)); // last word
    tbl.push_back(mk(0, 3'd5, 32'h1FE, 32'h0,        32'h00000BAD, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      txn(0, tbl[i], $sformatf("vec%0d", i));
      if (i == 21) chk("mem100.after_faults", u_w1.mem[32'h100 * 8 +: 32], 32'hCAFEBABE);
    end

    // Backpressure: response held, foreign request ignored
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chkb("bp.rise", rsp_valid[0], 1'b1);
    for (int c = 0; c < 7; c++) begin
      req_valid[0] = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h80; req_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      chkb("bp.valid", rsp_valid[0], 1'b1);
      chk("bp.rdata", rsp_rdata[0], 32'h9234F058);
      chkb("bp.error", rsp_error[0], 1'b0);
      chkb("bp.req_ready", req_ready[0], 1'b0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chkb("bp.release_valid", rsp_valid[0], 1'b0);
    chkb("bp.release_ready", req_ready[0], 1'b1);
    chk("bp.rdata_hold", rsp_rdata[0], 32'h9234F058);
    txn(0, mk(0, 3'd2, 32'h80, 32'h0, 32'h9234F058, 0), "bp.readback");

    // Reset during WAIT: store abandoned
    txn(1, mk(1, 3'd2, 32'h40, 32'h0, 32'h0, 0), "w4.clear");
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h12345678;
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) seen = 1'b1;
    end
    chkb("w4.no_rsp", seen, 1'b0);
    txn(1, mk(0, 3'd2, 32'h40, 32'h0, 32'h00000000, 0), "w4.readback");

    // Reset during RESP: store already committed
    txn(2, mk(1, 3'd2, 32'h40, 32'h0, 32'h0, 0), "w0.clear");
    rsp_ready[2] = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h12345678;
    req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chkb("w0.in_resp", rsp_valid[2], 1'b1);
    rst[2] = 1'b1;
    @(negedge clk);
    chkb("w0.rst_valid", rsp_valid[2], 1'b0);
    rst[2] = 1'b0;
    rsp_ready[2] = 1'b1;
    txn(2, mk(0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0), "w0.readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
